lenet_stream_loader: RTL and testbench
======================================

LENET_STREAM_LOADER -- requirements
Module: lenet_stream_loader

Interface
REQ-001 Parameter K_CH, default K_CHANNELS (package), number of 32-bit lanes per packed write.
REQ-002 Parameter LEN_W, default 16, width of word-count field.
REQ-003 clk_i  in  1  single clock; all logic rising-edge.
REQ-004 rst_async_i  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid_i/cmd_ready_o  in/out  1/1  command handshake.
REQ-006 cmd_target_i  in  2  0=global buffer, 1=weight buffer, 2=bias buffer, 3=illegal.
REQ-007 cmd_base_addr_i  in  32  first destination address.
REQ-008 cmd_len_i  in  LEN_W  number of 32-bit words to stream.
REQ-009 s_valid_i/s_ready_o/s_data_i  in/out/in  1/1/32  data stream handshake.
REQ-010 accel_busy_i  in  1  accelerator running; loading is stalled.
REQ-011 loader_target_sel_o  out  2  registered target.
REQ-012 loader_wr_en_o  out  1  one-cycle write strobe.
REQ-013 loader_wr_addr_o  out  32  write address.
REQ-014 loader_wr_data_o  out  K_CH*32  packed write data, lane k in bits [32k+31:32k].
REQ-015 busy_o / done_o / err_o  out  1 each  command active / completion pulse / rejection pulse.
REQ-016 checksum_o  out  32  running checksum (see Configuration).

Function
REQ-017 FSM states: IDLE, STREAM, FLUSH, DONE.
REQ-018 IDLE: cmd_ready_o=1 iff !accel_busy_i; transfer on cmd_valid_i&cmd_ready_o latches target, base, len.
REQ-019 Command with len==0 or target==3: err_o pulses 1 cycle after acceptance, no write, stay IDLE.
REQ-020 Legal command: IDLE->STREAM, word counter and lane index cleared, busy_o=1 until DONE exits.
REQ-021 STREAM: s_ready_o=!accel_busy_i; a word is accepted on s_valid_i&s_ready_o; s_ready_o=0 in all other states.
REQ-022 Target 0: each accepted word yields wr_en one cycle later, addr=base+word_idx, lane0=word, other lanes 0.
REQ-023 Targets 1/2: accepted word written into lane (word_idx mod K_CH); when lane K_CH-1 is filled, wr_en one cycle later, addr=base+group_idx, lane buffer cleared.
REQ-024 Last word accepted: packed target with partial group -> FLUSH (one write, unfilled lanes 0, addr=base+group_idx); else -> DONE.
REQ-025 DONE: done_o=1 exactly one cycle, then IDLE.
REQ-026 Address arithmetic modulo 2^32; wrap permitted, not flagged.
REQ-027 All outputs registered; loader_wr_en_o never high in IDLE or for rejected commands.
REQ-028 accel_busy_i rising mid-STREAM: pending registered write still issues; further acceptance stalls until low.

Reset
REQ-029 rst_async_i asserted: state IDLE, counters, lane buffer, all outputs 0 immediately; in-flight command discarded, no partial write.
REQ-030 First command accepted no earlier than first edge after rst_async_i deasserts.

Configuration
REQ-031 Macro LOADER_CHECKSUM_EN defined: checksum_o = 32-bit modular sum of all words accepted in current command, cleared on command acceptance, held after DONE.
REQ-032 Macro undefined: checksum_o tied to 0, no adder instantiated.

Structure
REQ-033 K_CHANNELS, loader target enum (TGT_GB, TGT_WB, TGT_BB), FSM state typedef in shared package lenet_pkg.
REQ-034 One sub-module: loader_lane_packer (lane buffer, lane index, full/flush write generation).

Verification
REQ-035 Target 0, base 0x100, len 3, words 0xA,0xB,0xC -> writes @0x100/0x101/0x102 lane0=A/B/C, done_o once.
REQ-036 Target 1, K_CH=6, base 0, len 8 -> write @0 lanes 0..5 = words 0..5; FLUSH write @1 lanes0..1 = words 6..7, lanes2..5 = 0.
REQ-037 Target 3 or len 0 -> err_o single pulse, no wr_en, cmd_ready_o returns 1.
REQ-038 accel_busy_i=1 during STREAM for 5 cycles -> s_ready_o=0 those cycles, no words lost, addresses contiguous.
REQ-039 rst_async_i pulse after 4 of 6 words on target 2 -> outputs 0 same cycle, no flush write, next command starts at its base.
REQ-040 LOADER_CHECKSUM_EN, words 0xFFFFFFFF,0x2 -> checksum_o=0x00000001; without macro checksum_o=0.

Source files
------------

// File: rtl/lenet_pkg.sv
// ---------------------------------------------------------------------------
// lenet_pkg
// Shared definitions for the LeNet stream loader:
//   K_CHANNELS     : number of 32-bit lanes in one packed buffer write
//   loader_tgt_e   : destination buffer selector carried by a load command
//   loader_state_e : loader control FSM state encoding
// ---------------------------------------------------------------------------
package lenet_pkg;

    localparam int K_CHANNELS = 6;

    typedef enum logic [1:0] {
        TGT_GB  = 2'd0,   // global buffer, one word per write
        TGT_WB  = 2'd1,   // weight buffer, K_CHANNELS words per write
        TGT_BB  = 2'd2,   // bias buffer,   K_CHANNELS words per write
        TGT_ILL = 2'd3    // reserved, command is rejected
    } loader_tgt_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } loader_state_e;

endpackage

// File: rtl/loader_lane_packer.sv
// ---------------------------------------------------------------------------
// loader_lane_packer
// Collects consecutive 32-bit words into a K_CH-lane buffer and requests a
// packed write when the last lane fills or when a flush is requested.
// The request and its data are combinational; the parent registers them.
//
// Ports
//   clk_i, rst_async_i : clock, asynchronous active-high reset
//   clear_i            : new command, empty the buffer and restart at lane 0
//   word_valid_i       : word_i is accepted this cycle
//   word_i             : accepted 32-bit word
//   flush_i            : emit the partially filled buffer (unfilled lanes 0)
//   wr_req_o           : a packed write must be issued this cycle
//   wr_data_o          : packed write data, lane k in bits [32k+31:32k]
// ---------------------------------------------------------------------------
module loader_lane_packer
    import lenet_pkg::*;
#(
    parameter int K_CH = K_CHANNELS
) (
    input  logic                 clk_i,
    input  logic                 rst_async_i,
    input  logic                 clear_i,
    input  logic                 word_valid_i,
    input  logic [31:0]          word_i,
    input  logic                 flush_i,
    output logic                 wr_req_o,
    output logic [K_CH*32-1:0]   wr_data_o
);

    localparam int LANE_W = (K_CH > 1) ? $clog2(K_CH) : 1;

    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [K_CH-1:0][31:0]     buf_q, buf_d;
    logic [K_CH-1:0][31:0]     merged;

    // NOTE: every signal assigned in always_comb gets a default at the top;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        merged   = buf_q;
        if (word_valid_i) begin
            merged[lane_q] = word_i;
        end
        buf_d    = merged;
        lane_d   = lane_q;
        wr_req_o = 1'b0;

        if (clear_i) begin
            buf_d  = '0;
            lane_d = '0;
        end else if (flush_i) begin
            wr_req_o = 1'b1;
            buf_d    = '0;
            lane_d   = '0;
        end else if (word_valid_i) begin
            if (lane_q == LANE_W'(K_CH - 1)) begin
                // Last lane filled: write the merged group and start over.
                wr_req_o = 1'b1;
                buf_d    = '0;
                lane_d   = '0;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end
    end

    assign wr_data_o = merged;

    // NOTE: the lane buffer is reset as well: a flush after reset must
    // never expose stale words in the unfilled lanes. Sequential state is
    // updated with non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            lane_q <= '0;
            buf_q  <= '0;
        end else begin
            lane_q <= lane_d;
            buf_q  <= buf_d;
        end
    end

endmodule

// File: rtl/lenet_stream_loader.sv
// ---------------------------------------------------------------------------
// lenet_stream_loader
// Accepts a load command (target, base address, word count), then streams
// that many 32-bit words into the selected accelerator buffer. Global-buffer
// words are written one per address; weight/bias words are packed K_CH per
// address, with a final flush write for a partial group.
//
// Ports
//   clk_i, rst_async_i        : clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o   : command handshake
//   cmd_target_i/base/len     : command fields
//   s_valid_i/s_ready_o/s_data_i : word stream handshake
//   accel_busy_i              : accelerator running, stalls all acceptance
//   loader_target_sel_o       : target of the current/last command
//   loader_wr_en_o/addr/data  : one-cycle buffer write
//   busy_o/done_o/err_o       : command active / completion / rejection
//   checksum_o                : modular sum of the command's words
//
// Build option: define LOADER_CHECKSUM_EN to enable the checksum; otherwise
// checksum_o is tied to zero.
// ---------------------------------------------------------------------------
module lenet_stream_loader
    import lenet_pkg::*;
#(
    parameter int K_CH  = K_CHANNELS,
    parameter int LEN_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_async_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_target_i,
    input  logic [31:0]          cmd_base_addr_i,
    input  logic [LEN_W-1:0]     cmd_len_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [31:0]          s_data_i,
    input  logic                 accel_busy_i,
    output logic [1:0]           loader_target_sel_o,
    output logic                 loader_wr_en_o,
    output logic [31:0]          loader_wr_addr_o,
    output logic [K_CH*32-1:0]   loader_wr_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [31:0]          checksum_o
);

    loader_state_e        state_q, state_d;
    loader_tgt_e          tgt_q, tgt_d;
    logic [31:0]          base_q, base_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;     // words accepted so far
    logic [31:0]          grp_q, grp_d;     // packed groups written so far
    logic                 wr_en_q, wr_en_d;
    logic [31:0]          wr_addr_q, wr_addr_d;
    logic [K_CH*32-1:0]   wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 cmd_fire, s_fire, cmd_illegal, is_last, packed_tgt;
    logic                 pk_clear, pk_valid, pk_flush, pk_wr_req;
    logic [K_CH*32-1:0]   pk_data;

    // Handshake readies decode the state register directly so a stall on
    // accel_busy_i blocks acceptance in the very cycle it is raised.
    assign cmd_ready_o = (state_q == ST_IDLE) && !accel_busy_i && !rst_async_i;
    assign s_ready_o   = (state_q == ST_STREAM) && !accel_busy_i;

    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign s_fire      = s_valid_i && s_ready_o;
    assign cmd_illegal = (cmd_len_i == '0) || (cmd_target_i == TGT_ILL);
    assign is_last     = (cnt_q == len_q - LEN_W'(1));
    assign packed_tgt  = (tgt_q != TGT_GB);

    loader_lane_packer #(
        .K_CH (K_CH)
    ) u_packer (
        .clk_i        (clk_i),
        .rst_async_i  (rst_async_i),
        .clear_i      (pk_clear),
        .word_valid_i (pk_valid),
        .word_i       (s_data_i),
        .flush_i      (pk_flush),
        .wr_req_o     (pk_wr_req),
        .wr_data_o    (pk_data)
    );

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        grp_d     = grp_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = 1'b0;
        pk_clear  = 1'b0;
        pk_valid  = 1'b0;
        pk_flush  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    tgt_d    = loader_tgt_e'(cmd_target_i);
                    base_d   = cmd_base_addr_i;
                    len_d    = cmd_len_i;
                    cnt_d    = '0;
                    grp_d    = '0;
                    pk_clear = 1'b1;
                    if (cmd_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end

            ST_STREAM: begin
                if (s_fire) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (!packed_tgt) begin
                        wr_en_d         = 1'b1;
                        wr_addr_d       = base_q + 32'(cnt_q);
                        wr_data_d       = '0;
                        wr_data_d[31:0] = s_data_i;
                    end else begin
                        pk_valid = 1'b1;
                        if (pk_wr_req) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = base_q + grp_q;
                            wr_data_d = pk_data;
                            grp_d     = grp_q + 32'd1;
                        end
                    end
                    if (is_last) begin
                        // A packed command whose last word did not complete
                        // a group still owes one write.
                        state_d = (packed_tgt && !pk_wr_req) ? ST_FLUSH : ST_DONE;
                    end
                end
            end

            ST_FLUSH: begin
                pk_flush  = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = base_q + grp_q;
                wr_data_d = pk_data;
                state_d   = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs follow the next state so they line up with it.
    assign busy_d = (state_d != ST_IDLE);
    assign done_d = (state_d == ST_DONE);

    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            state_q   <= ST_IDLE;
            tgt_q     <= TGT_GB;
            base_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            grp_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            grp_q     <= grp_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] sum_q;

    // Cleared by every accepted command, held once the command completes.
    always_ff @(posedge clk_i or posedge rst_async_i) begin
        if (rst_async_i) begin
            sum_q <= '0;
        end else if (cmd_fire) begin
            sum_q <= '0;
        end else if (s_fire) begin
            sum_q <= sum_q + s_data_i;
        end
    end

    assign checksum_o = sum_q;
`else
    assign checksum_o = '0;
`endif

    assign loader_target_sel_o = tgt_q;
    assign loader_wr_en_o      = wr_en_q;
    assign loader_wr_addr_o    = wr_addr_q;
    assign loader_wr_data_o    = wr_data_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign err_o               = err_q;

endmodule

// File: tb/tb_lenet_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_lenet_stream_loader
// Directed bench for lenet_stream_loader. A list-level model turns each
// command and its words into the writes that must appear; one monitor
// compares every DUT write against that list. Literal expectations pin the
// model on the key cases. Honors LOADER_CHECKSUM_EN for checksum_o.
// ---------------------------------------------------------------------------
module tb_lenet_stream_loader;
    import lenet_pkg::*;

    localparam int K  = K_CHANNELS;
    localparam int DW = K * 32;

    typedef struct {
        logic [31:0]   addr;
        logic [DW-1:0] data;
        logic [1:0]    tgt;
    } wr_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready_o;
    logic [1:0]      cmd_target = '0;
    logic [31:0]     cmd_base = '0;
    logic [15:0]     cmd_len = '0;
    logic            s_valid = 1'b0;
    logic            s_ready_o;
    logic [31:0]     s_data = '0;
    logic            accel_busy = 1'b0;
    logic [1:0]      tgt_sel_o;
    logic            wr_en_o;
    logic [31:0]     wr_addr_o;
    logic [DW-1:0]   wr_data_o;
    logic            busy_o, done_o, err_o;
    logic [31:0]     checksum_o;

    int              n_checks = 0;
    int              n_fail   = 0;
    int              done_seen = 0;
    int              err_seen  = 0;
    wr_t             exp_q[$];
    wr_t             obs_q[$];
    logic [31:0]     wbuf [0:15];
    logic [31:0]     exp_sum;

    always #5 clk = ~clk;

    lenet_stream_loader dut (
        .clk_i               (clk),
        .rst_async_i         (rst),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready_o),
        .cmd_target_i        (cmd_target),
        .cmd_base_addr_i     (cmd_base),
        .cmd_len_i           (cmd_len),
        .s_valid_i           (s_valid),
        .s_ready_o           (s_ready_o),
        .s_data_i            (s_data),
        .accel_busy_i        (accel_busy),
        .loader_target_sel_o (tgt_sel_o),
        .loader_wr_en_o      (wr_en_o),
        .loader_wr_addr_o    (wr_addr_o),
        .loader_wr_data_o    (wr_data_o),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .err_o               (err_o),
        .checksum_o          (checksum_o)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_checksum();
`ifdef LOADER_CHECKSUM_EN
        return exp_sum;
`else
        return 32'h0;
`endif
    endfunction

    // Model: the writes a command must produce, derived from its word list.
    task automatic model_cmd(input int tgt, input logic [31:0] base, input int len);
        wr_t e;
        exp_sum = 32'h0;
        for (int i = 0; i < len; i++) exp_sum = exp_sum + wbuf[i];
        if (len == 0 || tgt == 3) return;
        if (tgt == 0) begin
            for (int i = 0; i < len; i++) begin
                e.addr = base + 32'(i);
                e.data = '0;
                e.data[31:0] = wbuf[i];
                e.tgt = 2'(tgt);
                exp_q.push_back(e);
            end
        end else begin
            for (int g = 0; g * K < len; g++) begin
                e.addr = base + 32'(g);
                e.data = '0;
                for (int k = 0; k < K; k++)
                    if (g * K + k < len) e.data[k*32 +: 32] = wbuf[g * K + k];
                e.tgt = 2'(tgt);
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: every write must be the next one the model predicts.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en_o) begin
                wr_t o;
                o.addr = wr_addr_o; o.data = wr_data_o; o.tgt = tgt_sel_o;
                obs_q.push_back(o);
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", wr_addr_o, 'x);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", o.addr, e.addr);
                    check("wr_data", o.data, e.data);
                    check("wr_target", o.tgt, e.tgt);
                end
            end
            if (done_o) done_seen++;
            if (err_o) err_seen++;
            if (accel_busy) check("ready_while_stalled", {cmd_ready_o, s_ready_o}, 0);
        end
    end

    task automatic send_cmd(input logic [1:0] tgt, input logic [31:0] base, input logic [15:0] len);
        bit acc = 1'b0;
        cmd_target = tgt; cmd_base = base; cmd_len = len; cmd_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk); acc = cmd_ready_o;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check("cmd_accepted", acc, 1);
    endtask

    task automatic send_word(input logic [31:0] w);
        bit acc = 1'b0;
        s_data = w; s_valid = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk); acc = s_ready_o;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("word_accepted", acc, 1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int c = 0; c < 50 && !idle; c++) begin
            @(negedge clk);
            idle = !busy_o && !done_o;
        end
        check("returned_idle", idle, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input int tgt, input logic [31:0] base, input int len);
        int d0 = done_seen;
        model_cmd(tgt, base, len);
        send_cmd(2'(tgt), base, 16'(len));
        check("busy_after_accept", busy_o, 1);
        for (int i = 0; i < len; i++) send_word(wbuf[i]);
        wait_idle();
        check("done_single_pulse", done_seen - d0, 1);
        check("checksum", checksum_o, exp_checksum());
    endtask

    task automatic check_obs(input string name, input int idx, input logic [31:0] addr, input logic [DW-1:0] data);
        if (idx >= obs_q.size()) begin
            check({name, "_present"}, 0, 1);
        end else begin
            check({name, "_addr"}, obs_q[idx].addr, addr);
            check({name, "_data"}, obs_q[idx].data, data);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_wr_en"}, wr_en_o, 0);
        check({name, "_wr_addr"}, wr_addr_o, 0);
        check({name, "_wr_data"}, wr_data_o, 0);
        check({name, "_flags"}, {busy_o, done_o, err_o, tgt_sel_o}, 0);
        check({name, "_readies"}, {cmd_ready_o, s_ready_o}, 0);
        check({name, "_checksum"}, checksum_o, 0);
    endtask

    initial begin
        int o0, e0, d0;

        // Reset state
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Global buffer, one word per address
        wbuf[0] = 32'hA; wbuf[1] = 32'hB; wbuf[2] = 32'hC;
        o0 = obs_q.size();
        run_cmd(0, 32'h100, 3);
        check_obs("gb_w0", o0,     32'h100, 192'hA);
        check_obs("gb_w2", o0 + 2, 32'h102, 192'hC);
        check("gb_write_count", obs_q.size() - o0, 3);

        // Weight buffer, one full group plus a flushed partial group
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h10 + i;
        o0 = obs_q.size();
        run_cmd(1, 32'h0, 8);
        check_obs("wb_full", o0, 32'h0,
                  192'h00000015_00000014_00000013_00000012_00000011_00000010);
        check_obs("wb_flush", o0 + 1, 32'h1, 192'h00000017_00000016);
        check("wb_write_count", obs_q.size() - o0, 2);

        // Bias buffer, exact groups (no flush), address wraps past 2^32-1
        for (int i = 0; i < 12; i++) wbuf[i] = 32'h100 + i;
        o0 = obs_q.size();
        run_cmd(2, 32'hFFFF_FFFF, 12);
        check_obs("bb_wrap", o0 + 1, 32'h0,
                  192'h0000010B_0000010A_00000109_00000108_00000107_00000106);
        check("bb_write_count", obs_q.size() - o0, 2);

        // Rejected commands: illegal target, then zero length
        o0 = obs_q.size(); e0 = err_seen;
        model_cmd(3, 32'h500, 4);
        send_cmd(2'd3, 32'h500, 16'd4);
        repeat (3) @(posedge clk); #1;
        check("err_illegal_target", err_seen - e0, 1);
        check("err_busy_stays_low", busy_o, 0);
        model_cmd(0, 32'h600, 0);
        send_cmd(2'd0, 32'h600, 16'd0);
        repeat (3) @(posedge clk); #1;
        check("err_zero_len", err_seen - e0, 2);
        check("err_no_writes", obs_q.size() - o0, 0);
        check("err_cmd_ready_back", cmd_ready_o, 1);

        // Accelerator stall mid-stream for 5 cycles
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h7000 + i;
        o0 = obs_q.size(); d0 = done_seen;
        model_cmd(0, 32'h200, 4);
        send_cmd(2'd0, 32'h200, 16'd4);
        send_word(wbuf[0]);
        send_word(wbuf[1]);
        s_data = wbuf[2]; s_valid = 1'b1; accel_busy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_s_ready", s_ready_o, 0);
            @(posedge clk); #1;
        end
        accel_busy = 1'b0;
        send_word(wbuf[2]);
        send_word(wbuf[3]);
        wait_idle();
        check("stall_write_count", obs_q.size() - o0, 4);
        check_obs("stall_w3", o0 + 3, 32'h203, 192'h7003);
        check("stall_done", done_seen - d0, 1);

        // Reset after 4 of 6 bias words: no flush, clean restart
        for (int i = 0; i < 6; i++) wbuf[i] = 32'h900 + i;
        o0 = obs_q.size(); d0 = done_seen;
        send_cmd(2'd2, 32'h40, 16'd6);
        for (int i = 0; i < 4; i++) send_word(wbuf[i]);
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wbuf[0] = 32'h55; wbuf[1] = 32'h66;
        run_cmd(0, 32'h300, 2);
        check("post_reset_no_done_for_aborted", done_seen - d0, 1);
        check_obs("post_reset_w0", o0, 32'h300, 192'h55);
        check("post_reset_write_count", obs_q.size() - o0, 2);

        // Checksum wraps modulo 2^32
        wbuf[0] = 32'hFFFF_FFFF; wbuf[1] = 32'h2;
        run_cmd(0, 32'h400, 2);
`ifdef LOADER_CHECKSUM_EN
        check("checksum_wrap_literal", checksum_o, 32'h1);
`else
        check("checksum_disabled_literal", checksum_o, 32'h0);
`endif

        repeat (3) @(posedge clk); #1;
        check("expected_writes_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
